fetch_if2id: RTL and testbench
==============================

Name: fetch_if2id

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the MIPS pipeline.
- Holds the PC and issues one-outstanding requests to instruction memory over a valid/ready request, valid-only response interface.
- Presents PC_incr4_ID / instr_ID / valid_ID to the decode stage, whose outputs feed the ID/EX register.
- Handles decode stall, flush and branch/jump redirect, using a one-entry hold buffer.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset (bits [1:0] must be 0)

Ports:
clk  input  1  pipeline clock, rising edge
rst_n  input  1  asynchronous active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  imem accepts request this cycle
imem_addr  output  32  fetch address (= PC)
imem_rsp_valid  input  1  response valid, one cycle per accepted request, at least 1 cycle after accept
imem_rsp_data  input  32  fetched instruction
stall_ID  input  1  hold IF/ID contents
flush_ID  input  1  squash IF/ID contents
redirect_valid  input  1  one-cycle pulse, load new PC
redirect_target  input  32  new PC; bits [1:0] ignored (forced 0)
PC_incr4_ID  output  32  fetch PC + 4 of instruction in ID
instr_ID  output  32  instruction in ID
valid_ID  output  1  instr_ID is a live instruction

Behaviour:
- Reset (async, rst_n low):
  - PC=RESET_PC, state=REQ, drop=0, buffer empty.
  - Outputs: imem_req_valid=0, PC_incr4_ID=0, instr_ID=0, valid_ID=0.
  - imem_req_valid first rises in the first cycle after rst_n deasserts.
  - Reset mid-transaction abandons everything; any response arriving after reset is ignored until a new request is accepted.
- States:
  - REQ: imem_req_valid=1, imem_addr=PC. On imem_req_valid&imem_req_ready: fetch_pc<=PC, go WAIT.
  - WAIT: imem_req_valid=0.
    - On imem_rsp_valid with drop=1: discard the response, drop<=0, go REQ.
    - Otherwise, on imem_rsp_valid: if IF/ID can load (stall_ID=0), load IF/ID, PC<=fetch_pc+4, go REQ. Else write the data to the buffer, PC<=fetch_pc+4, go HOLD.
  - HOLD: imem_req_valid=0. When stall_ID=0, load IF/ID from the buffer, go REQ.
- IF/ID load: instr_ID<=data, PC_incr4_ID<=fetch_pc+4, valid_ID<=1.
- IF/ID idle: with stall_ID=0 and no load this cycle, valid_ID<=0 (bubble). instr_ID and PC_incr4_ID hold their values.
- Stall: stall_ID=1 holds all three IF/ID outputs.
- Flush: flush_ID=1 sets valid_ID<=0 and instr_ID<=32'h0 (NOP). Priority: flush > stall > load.
  - Flush and response in the same cycle: the response is still consumed normally (loaded into IF/ID or buffer) unless a redirect discards it.
- Redirect: PC<=redirect_target&~3. Redirect has priority over the sequential PC update.
  - REQ, no handshake: the new PC is used from the next cycle.
  - REQ, with handshake the same cycle: the accepted request is stale; drop<=1.
  - WAIT, no response: drop<=1.
  - WAIT, response the same cycle: discard the response, go REQ.
  - HOLD: discard the buffer, go REQ.
  - The upstream hazard unit drives flush_ID together with redirect when required; redirect itself does not touch IF/ID.
- Arithmetic: PC+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- Latency and throughput:
  - Minimum latency is 1 cycle from response to valid_ID.
  - Best-case throughput is one instruction per 2 cycles, because requests are not pipelined.
- imem_rsp_valid in REQ or HOLD is a protocol violation and is ignored.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined:
  - Adds output ports perf_stall_cnt[31:0] and perf_drop_cnt[31:0], both reset to 0.
  - perf_stall_cnt increments each cycle in HOLD.
  - perf_drop_cnt increments each discarded response or discarded buffer entry.
  - Both counters saturate at 32'hFFFF_FFFF.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
- Reset/start: RESET_PC=32'h0000_0040, release rst_n, ready=1, responses with 1-cycle latency, data 32'hAAAA_0001 then 32'hAAAA_0002 -> imem_addr 0x40 then 0x44; valid_ID=1 with PC_incr4_ID=0x44/instr_ID=32'hAAAA_0001, then 0x48/32'hAAAA_0002.
- Stall during response: stall_ID=1 for 3 cycles while the response 32'h1234_5678 arrives -> IF/ID unchanged, state HOLD, no request issued; after release, instr_ID=32'h1234_5678, next imem_addr=fetch_pc+4.
- Redirect in WAIT: redirect to 32'h0000_1003 before the response -> the next response is discarded (valid_ID stays 0); the next imem_addr is 0x1000; perf_drop_cnt=1 if FETCH_PERF_EN.
- Redirect on the same cycle as a response in HOLD/WAIT -> no load into IF/ID, imem_addr=target the next cycle.
- Flush with stall: stall_ID=1 and flush_ID=1 together -> valid_ID=0, instr_ID=0.
- Wrap: redirect to 32'hFFFF_FFFC -> PC_incr4_ID=32'h0000_0000, next imem_addr=0x0.
- Async reset mid-WAIT -> all outputs 0 immediately; a late imem_rsp_valid is ignored.

Source files
------------

// File: rtl/fetch_if2id.sv
// rtl/fetch_if2id.sv - instruction-fetch stage with IF/ID pipeline register
//
// Ports:
//   clk, rst_n              clock (rising edge), asynchronous active-low reset
//   imem_req_valid/ready    fetch request handshake, imem_addr = current PC
//   imem_rsp_valid/data     valid-only instruction response, one per accepted request
//   stall_ID, flush_ID      hold / squash the IF/ID register
//   redirect_valid/target   one-cycle pulse loading a new PC (target[1:0] forced to 0)
//   PC_incr4_ID, instr_ID,  IF/ID register contents presented to decode
//   valid_ID
//   perf_stall_cnt,         saturating counters, present only when FETCH_PERF_EN
//   perf_drop_cnt           is defined
//
// Optional feature macro: FETCH_PERF_EN

module fetch_if2id #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        stall_ID,
   input  logic        flush_ID,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] PC_incr4_ID,
   output logic [31:0] instr_ID,
   output logic        valid_ID
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_drop_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] fetch_pc_q, fetch_pc_d;
   logic        drop_q, drop_d;
   logic [31:0] buf_q, buf_d;
   logic        req_valid_q, req_valid_d;
   logic [31:0] pc_incr4_id_q, pc_incr4_id_d;
   logic [31:0] instr_id_q, instr_id_d;
   logic        valid_id_q, valid_id_d;

   logic        load;
   logic [31:0] load_data;
   logic [31:0] redirect_pc;
   logic [31:0] seq_pc;

   assign redirect_pc = redirect_target & ~32'h0000_0003;
   assign seq_pc      = fetch_pc_q + 32'd4;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      fetch_pc_d    = fetch_pc_q;
      drop_d        = drop_q;
      buf_d         = buf_q;
      pc_incr4_id_d = pc_incr4_id_q;
      instr_id_d    = instr_id_q;
      valid_id_d    = valid_id_q;
      load          = 1'b0;
      load_data     = imem_rsp_data;

      case (state_q)
         ST_REQ: begin
            // req_valid_q is only high in REQ, so it doubles as the state qualifier
            if (req_valid_q && imem_req_ready) begin
               fetch_pc_d = pc_q;
               state_d    = ST_WAIT;
               // a redirect coinciding with the accept makes that request stale
               drop_d     = redirect_valid;
            end
            if (redirect_valid) begin
               pc_d = redirect_pc;
            end
         end
         ST_WAIT: begin
            if (imem_rsp_valid) begin
               if (drop_q || redirect_valid) begin
                  drop_d  = 1'b0;
                  state_d = ST_REQ;
                  if (redirect_valid) begin
                     pc_d = redirect_pc;
                  end
               end else begin
                  pc_d = seq_pc;
                  if (!stall_ID) begin
                     load    = 1'b1;
                     state_d = ST_REQ;
                  end else begin
                     buf_d   = imem_rsp_data;
                     state_d = ST_HOLD;
                  end
               end
            end else if (redirect_valid) begin
               drop_d = 1'b1;
               pc_d   = redirect_pc;
            end
         end
         ST_HOLD: begin
            if (redirect_valid) begin
               pc_d    = redirect_pc;
               state_d = ST_REQ;
            end else if (!stall_ID) begin
               load      = 1'b1;
               load_data = buf_q;
               state_d   = ST_REQ;
            end
         end
         default: begin
            state_d = ST_REQ;
         end
      endcase

      // IF/ID register: flush beats stall beats load; idle cycles insert a bubble
      if (flush_ID) begin
         valid_id_d = 1'b0;
         instr_id_d = 32'h0000_0000;
      end else if (stall_ID) begin
         valid_id_d = valid_id_q;
      end else if (load) begin
         instr_id_d    = load_data;
         pc_incr4_id_d = seq_pc;
         valid_id_d    = 1'b1;
      end else begin
         valid_id_d = 1'b0;
      end

      // registered request valid keeps the output low throughout reset
      req_valid_d = (state_d == ST_REQ);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_REQ;
         pc_q          <= RESET_PC;
         fetch_pc_q    <= RESET_PC;
         drop_q        <= 1'b0;
         buf_q         <= 32'h0000_0000;
         req_valid_q   <= 1'b0;
         pc_incr4_id_q <= 32'h0000_0000;
         instr_id_q    <= 32'h0000_0000;
         valid_id_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         fetch_pc_q    <= fetch_pc_d;
         drop_q        <= drop_d;
         buf_q         <= buf_d;
         req_valid_q   <= req_valid_d;
         pc_incr4_id_q <= pc_incr4_id_d;
         instr_id_q    <= instr_id_d;
         valid_id_q    <= valid_id_d;
      end
   end

   assign imem_req_valid = req_valid_q;
   assign imem_addr      = pc_q;
   assign PC_incr4_ID    = pc_incr4_id_q;
   assign instr_ID       = instr_id_q;
   assign valid_ID       = valid_id_q;

`ifdef FETCH_PERF_EN
   logic [31:0] perf_stall_cnt_q, perf_stall_cnt_d;
   logic [31:0] perf_drop_cnt_q, perf_drop_cnt_d;
   logic        drop_evt;

   // a response is thrown away when stale or hit by a redirect; a buffered one on redirect
   assign drop_evt = ((state_q == ST_WAIT) && imem_rsp_valid && (drop_q || redirect_valid)) ||
                     ((state_q == ST_HOLD) && redirect_valid);

   always_comb begin
      perf_stall_cnt_d = perf_stall_cnt_q;
      perf_drop_cnt_d  = perf_drop_cnt_q;
      if ((state_q == ST_HOLD) && (perf_stall_cnt_q != 32'hFFFF_FFFF)) begin
         perf_stall_cnt_d = perf_stall_cnt_q + 32'd1;
      end
      if (drop_evt && (perf_drop_cnt_q != 32'hFFFF_FFFF)) begin
         perf_drop_cnt_d = perf_drop_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt_q <= 32'h0000_0000;
         perf_drop_cnt_q  <= 32'h0000_0000;
      end else begin
         perf_stall_cnt_q <= perf_stall_cnt_d;
         perf_drop_cnt_q  <= perf_drop_cnt_d;
      end
   end

   assign perf_stall_cnt = perf_stall_cnt_q;
   assign perf_drop_cnt  = perf_drop_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_if2id.sv
// tb/tb_fetch_if2id.sv - self-checking bench for fetch_if2id

module tb_fetch_if2id;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   logic        stall_ID;
   logic        flush_ID;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] PC_incr4_ID;
   logic [31:0] instr_ID;
   logic        valid_ID;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_drop_cnt;
`endif

   fetch_if2id #(.RESET_PC(32'h0000_0040)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .imem_req_valid  (imem_req_valid),
      .imem_req_ready  (imem_req_ready),
      .imem_addr       (imem_addr),
      .imem_rsp_valid  (imem_rsp_valid),
      .imem_rsp_data   (imem_rsp_data),
      .stall_ID        (stall_ID),
      .flush_ID        (flush_ID),
      .redirect_valid  (redirect_valid),
      .redirect_target (redirect_target),
      .PC_incr4_ID     (PC_incr4_ID),
      .instr_ID        (instr_ID),
      .valid_ID        (valid_ID)
`ifdef FETCH_PERF_EN
      ,
      .perf_stall_cnt  (perf_stall_cnt),
      .perf_drop_cnt   (perf_drop_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc4;
      logic [31:0] instr;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   lat     = 1;
   logic prev_valid = 1'b0;

   logic [31:0] mem [logic [31:0]];

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return ~a;
   endfunction

   // instruction memory: answers each accepted request after lat cycles
   logic        r_busy = 1'b0;
   int          r_cnt  = 0;
   logic [31:0] r_addr = 32'h0;
   logic        r_hs;
   logic [31:0] r_a;
   always @(posedge clk) begin
      r_hs = imem_req_valid && imem_req_ready;
      r_a  = imem_addr;
      #1;
      imem_rsp_valid = 1'b0;
      if (r_hs) begin
         r_busy = 1'b1;
         r_cnt  = lat;
         r_addr = r_a;
      end
      if (r_busy) begin
         r_cnt = r_cnt - 1;
         if (r_cnt == 0) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_val(r_addr);
            r_busy         = 1'b0;
         end
      end
   end

   // advance one cycle, then pop the scoreboard for every newly presented instruction
   task automatic tick();
      logic st;
      exp_t e;
      st = stall_ID;
      @(posedge clk);
      #2;
      if (rst_n && valid_ID && !(st && prev_valid)) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: got pc4=%h instr=%h, required no instruction", PC_incr4_ID, instr_ID);
         end else begin
            e = sb.pop_front();
            if (PC_incr4_ID !== e.pc4 || instr_ID !== e.instr) begin
               n_fail++;
               $display("FAIL sb_if_id: got pc4=%h instr=%h, required pc4=%h instr=%h", PC_incr4_ID, instr_ID, e.pc4, e.instr);
            end
         end
      end
      prev_valid = valid_ID;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; imem_req_ready = 1'b1; lat = 1;
      stall_ID = 1'b0; flush_ID = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
      tick(); tick();
      n_tests++; if (imem_req_valid !== 1'b0 || valid_ID !== 1'b0) begin n_fail++; $display("FAIL reset_valids: got req=%b vid=%b, required 0 0", imem_req_valid, valid_ID); end
      n_tests++; if (PC_incr4_ID !== 32'h0 || instr_ID !== 32'h0) begin n_fail++; $display("FAIL reset_ifid: got pc4=%h instr=%h, required 0 0", PC_incr4_ID, instr_ID); end
`ifdef FETCH_PERF_EN
      n_tests++; if (perf_stall_cnt !== 32'h0 || perf_drop_cnt !== 32'h0) begin n_fail++; $display("FAIL reset_perf: got %h %h, required 0 0", perf_stall_cnt, perf_drop_cnt); end
`endif
      sb.push_back('{pc4: 32'h0000_0044, instr: 32'hAAAA_0001});
      sb.push_back('{pc4: 32'h0000_0048, instr: 32'hAAAA_0002});
      rst_n = 1'b1;
      tick();
      n_tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL start_req: got req=%b addr=%h, required 1 00000040", imem_req_valid, imem_addr); end
      tick();
      n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL wait_no_req: got %b, required 0", imem_req_valid); end
      tick();
      n_tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h44) begin n_fail++; $display("FAIL second_req: got req=%b addr=%h, required 1 00000044", imem_req_valid, imem_addr); end
      tick(); tick();
      n_tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h48) begin n_fail++; $display("FAIL third_req: got req=%b addr=%h, required 1 00000048", imem_req_valid, imem_addr); end
      imem_req_ready = 1'b0;
      tick();
      n_tests++; if (valid_ID !== 1'b0 || sb.size() != 0) begin n_fail++; $display("FAIL start_drain: got vid=%b pending=%0d, required 0 0", valid_ID, sb.size()); end
   endtask

   task automatic test_stall();
      lat = 2;
      sb.push_back('{pc4: 32'h0000_004C, instr: 32'h1234_5678});
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0; stall_ID = 1'b1;
      tick(); tick();
      for (int i = 0; i < 2; i++) begin
         n_tests++;
         if (imem_req_valid !== 1'b0 || valid_ID !== 1'b0 || PC_incr4_ID !== 32'h48 || instr_ID !== 32'hAAAA_0002) begin
            n_fail++; $display("FAIL stall_hold: got req=%b vid=%b pc4=%h instr=%h, required 0 0 00000048 aaaa0002", imem_req_valid, valid_ID, PC_incr4_ID, instr_ID);
         end
         if (i == 0) tick();
      end
      stall_ID = 1'b0;
      tick();
      n_tests++; if (valid_ID !== 1'b1 || imem_req_valid !== 1'b1 || imem_addr !== 32'h4C) begin n_fail++; $display("FAIL stall_release: got vid=%b req=%b addr=%h, required 1 1 0000004c", valid_ID, imem_req_valid, imem_addr); end
`ifdef FETCH_PERF_EN
      n_tests++; if (perf_stall_cnt !== 32'd2) begin n_fail++; $display("FAIL perf_stall: got %0d, required 2", perf_stall_cnt); end
`endif
      tick();
   endtask

   task automatic test_redirect_wait();
      lat = 3; imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h0000_1003;
      tick();
      redirect_valid = 1'b0;
      n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_wait_req: got %b, required 0", imem_req_valid); end
      tick(); tick();
      n_tests++; if (valid_ID !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h1000) begin n_fail++; $display("FAIL redir_wait_drop: got vid=%b req=%b addr=%h, required 0 1 00001000", valid_ID, imem_req_valid, imem_addr); end
`ifdef FETCH_PERF_EN
      n_tests++; if (perf_drop_cnt !== 32'd1) begin n_fail++; $display("FAIL perf_drop1: got %0d, required 1", perf_drop_cnt); end
`endif
      sb.push_back('{pc4: 32'h0000_1004, instr: 32'hFFFF_EFFF});
      lat = 1; imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      tick();
      n_tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h1004) begin n_fail++; $display("FAIL redir_target_fetch: got req=%b addr=%h, required 1 00001004", imem_req_valid, imem_addr); end
   endtask

   task automatic test_redirect_rsp();
      lat = 2; imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      tick();
      redirect_valid = 1'b1; redirect_target = 32'h0000_2000;
      tick();
      redirect_valid = 1'b0;
      n_tests++; if (valid_ID !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h2000) begin n_fail++; $display("FAIL redir_rsp_wait: got vid=%b req=%b addr=%h, required 0 1 00002000", valid_ID, imem_req_valid, imem_addr); end
      lat = 1; imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0; stall_ID = 1'b1;
      tick();
      n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL hold_no_req: got %b, required 0", imem_req_valid); end
      redirect_valid = 1'b1; redirect_target = 32'h0000_3000;
      tick();
      redirect_valid = 1'b0; stall_ID = 1'b0;
      n_tests++; if (valid_ID !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h3000) begin n_fail++; $display("FAIL redir_hold: got vid=%b req=%b addr=%h, required 0 1 00003000", valid_ID, imem_req_valid, imem_addr); end
      tick();
      n_tests++; if (valid_ID !== 1'b0) begin n_fail++; $display("FAIL redir_hold_noload: got %b, required 0", valid_ID); end
`ifdef FETCH_PERF_EN
      n_tests++; if (perf_drop_cnt !== 32'd3 || perf_stall_cnt !== 32'd3) begin n_fail++; $display("FAIL perf_drop3: got drop=%0d stall=%0d, required 3 3", perf_drop_cnt, perf_stall_cnt); end
`endif
   endtask

   task automatic test_flush_stall();
      sb.push_back('{pc4: 32'h0000_3004, instr: 32'hFFFF_CFFF});
      lat = 1; imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      tick();
      n_tests++; if (valid_ID !== 1'b1) begin n_fail++; $display("FAIL flush_pre_load: got %b, required 1", valid_ID); end
      stall_ID = 1'b1; flush_ID = 1'b1;
      tick();
      stall_ID = 1'b0; flush_ID = 1'b0;
      n_tests++; if (valid_ID !== 1'b0 || instr_ID !== 32'h0 || PC_incr4_ID !== 32'h3004) begin n_fail++; $display("FAIL flush_stall: got vid=%b instr=%h pc4=%h, required 0 00000000 00003004", valid_ID, instr_ID, PC_incr4_ID); end
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0; flush_ID = 1'b1;
      tick();
      flush_ID = 1'b0;
      n_tests++; if (valid_ID !== 1'b0 || instr_ID !== 32'h0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h3008) begin n_fail++; $display("FAIL flush_rsp: got vid=%b instr=%h req=%b addr=%h, required 0 00000000 1 00003008", valid_ID, instr_ID, imem_req_valid, imem_addr); end
   endtask

   task automatic test_wrap();
      redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      n_tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req: got req=%b addr=%h, required 1 fffffffc", imem_req_valid, imem_addr); end
      sb.push_back('{pc4: 32'h0000_0000, instr: 32'h0000_0003});
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      tick();
      n_tests++; if (valid_ID !== 1'b1 || PC_incr4_ID !== 32'h0 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap: got vid=%b pc4=%h addr=%h, required 1 00000000 00000000", valid_ID, PC_incr4_ID, imem_addr); end
   endtask

   task automatic test_redirect_handshake();
      lat = 1; imem_req_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_0500;
      tick();
      imem_req_ready = 1'b0; redirect_valid = 1'b0;
      n_tests++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_hs_wait: got %b, required 0", imem_req_valid); end
      tick();
      n_tests++; if (valid_ID !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h500) begin n_fail++; $display("FAIL redir_hs_drop: got vid=%b req=%b addr=%h, required 0 1 00000500", valid_ID, imem_req_valid, imem_addr); end
`ifdef FETCH_PERF_EN
      n_tests++; if (perf_drop_cnt !== 32'd4) begin n_fail++; $display("FAIL perf_drop4: got %0d, required 4", perf_drop_cnt); end
`endif
   endtask

   task automatic test_async_reset();
      lat = 3; imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      rst_n = 1'b0;
      #1;
      n_tests++; if (imem_req_valid !== 1'b0 || valid_ID !== 1'b0 || instr_ID !== 32'h0 || PC_incr4_ID !== 32'h0) begin n_fail++; $display("FAIL async_reset: got req=%b vid=%b instr=%h pc4=%h, required all 0", imem_req_valid, valid_ID, instr_ID, PC_incr4_ID); end
`ifdef FETCH_PERF_EN
      n_tests++; if (perf_stall_cnt !== 32'h0 || perf_drop_cnt !== 32'h0) begin n_fail++; $display("FAIL async_reset_perf: got %h %h, required 0 0", perf_stall_cnt, perf_drop_cnt); end
`endif
      tick();
      rst_n = 1'b1;
      tick();
      n_tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL post_reset_req: got req=%b addr=%h, required 1 00000040", imem_req_valid, imem_addr); end
      tick();
      n_tests++; if (valid_ID !== 1'b0 || imem_req_valid !== 1'b1 || imem_addr !== 32'h40) begin n_fail++; $display("FAIL late_rsp_ignored: got vid=%b req=%b addr=%h, required 0 1 00000040", valid_ID, imem_req_valid, imem_addr); end
      sb.push_back('{pc4: 32'h0000_0044, instr: 32'hAAAA_0001});
      lat = 1; imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      tick();
      n_tests++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h44) begin n_fail++; $display("FAIL post_reset_fetch: got req=%b addr=%h, required 1 00000044", imem_req_valid, imem_addr); end
      tick();
   endtask

   initial begin
      mem[32'h0000_0040] = 32'hAAAA_0001;
      mem[32'h0000_0044] = 32'hAAAA_0002;
      mem[32'h0000_0048] = 32'h1234_5678;
      test_reset();
      test_stall();
      test_redirect_wait();
      test_redirect_rsp();
      test_flush_stall();
      test_wrap();
      test_redirect_handshake();
      test_async_reset();
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending instructions, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
